// File: rtl/vend_pkg.sv
// Shared types and sizing for the vend dispenser: FSM state encoding,
// request entry layout, FIFO depth and change-code width.
// Imported by vend_req_fifo and vend_dispenser.
package vend_pkg;

  localparam int CHANGE_W   = 2;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    WAIT_DROP,
    CHANGE,
    EJECT,
    WAIT_COIN
  } disp_state_t;

  typedef struct packed {
    logic                vend;
    logic [CHANGE_W-1:0] change;
  } vend_req_t;

endpackage

// File: rtl/vend_req_fifo.sv
// Request buffer: FIFO_DEPTH-entry synchronous FIFO of vend_req_t entries.
// Latency: a push is visible at the head one cycle later; pop_data is the current head.
// Backpressure: none upstream; a push into a full FIFO is dropped and flagged on ovf, unless a pop frees a slot in the same cycle.
module vend_req_fifo
  import vend_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  vend_req_t push_data,
  input  logic      pop,
  output vend_req_t pop_data,
  output logic      full,
  output logic      empty,
  output logic      ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  vend_req_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign ovf      = push && !do_push;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vend_dispenser.sv
// Dispense-side actuator controller: buffers {vend, change} requests, pulses the
// motor, awaits the drop sensor, then ejects owed coins with sense handshakes and timeouts.
// Optional stock counter and sold_out port are enabled by defining VEND_STOCK_EN.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 255
`ifdef VEND_STOCK_EN
  ,
  parameter int STOCK_INIT     = 15
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                out,
  input  logic [CHANGE_W-1:0] change,
  output logic                motor,
  input  logic                drop,
  output logic                eject,
  input  logic                coin_sense,
  output logic                busy,
  output logic                fault,
  output logic                ovf,
  output logic [7:0]          coins_paid
`ifdef VEND_STOCK_EN
  ,
  output logic                sold_out
`endif
);

  localparam int          MW   = $clog2(MOTOR_CYCLES + 1);
  localparam logic [7:0]  TMAX = 8'(TIMEOUT_CYCLES - 1);

  disp_state_t          state;
  logic [MW-1:0]        mcnt;
  logic [7:0]           tmr;
  logic [CHANGE_W-1:0]  remaining;
  logic                 sold_now;

  logic                 req_push;
  vend_req_t            req_in;
  vend_req_t            head;
  logic                 fifo_pop;
  logic                 fifo_empty;
  logic                 fifo_full_unused;
  logic                 fifo_ovf;

  assign req_push = out || (change != '0);
  assign req_in   = '{vend: out, change: change};
  assign fifo_pop = (state == IDLE) && !fifo_empty;
  // Both terms come straight from flops, so busy is a clean Moore decode.
  assign busy     = (state != IDLE) || !fifo_empty;

  vend_req_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push),
    .push_data (req_in),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .ovf       (fifo_ovf)
  );

`ifdef VEND_STOCK_EN
  logic [7:0] stock;

  // Product inventory: counts down on each confirmed drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      stock <= 8'(STOCK_INIT);
    end else if (state == WAIT_DROP && drop && stock != 8'd0) begin
      stock <= stock - 8'd1;
    end
  end

  assign sold_now = (stock == 8'd0);
  assign sold_out = sold_now;
`else
  assign sold_now = 1'b0;
`endif

  // Dispense sequencer with registered motor/eject/fault/ovf/coins_paid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      motor      <= 1'b0;
      eject      <= 1'b0;
      fault      <= 1'b0;
      ovf        <= 1'b0;
      coins_paid <= 8'd0;
      remaining  <= '0;
      mcnt       <= '0;
      tmr        <= 8'd0;
    end else begin
      ovf <= ovf | fifo_ovf;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            remaining <= head.change;
            if (head.vend && !sold_now) begin
              state <= MOTOR;
              motor <= 1'b1;
              mcnt  <= '0;
            end else begin
              state <= CHANGE;
            end
          end
        end
        MOTOR: begin
          if (mcnt == MW'(MOTOR_CYCLES - 1)) begin
            motor <= 1'b0;
            tmr   <= 8'd0;
            state <= WAIT_DROP;
          end else begin
            mcnt <= mcnt + 1'b1;
          end
        end
        WAIT_DROP: begin
          if (drop) begin
            state <= CHANGE;
          end else if (tmr == TMAX) begin
            // Product never seen: flag it but still pay the change owed.
            fault <= 1'b1;
            state <= CHANGE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        CHANGE: begin
          if (remaining == '0) begin
            state <= IDLE;
          end else begin
            eject <= 1'b1;
            state <= EJECT;
          end
        end
        EJECT: begin
          eject <= 1'b0;
          tmr   <= 8'd0;
          state <= WAIT_COIN;
        end
        WAIT_COIN: begin
          if (coin_sense) begin
            remaining  <= remaining - 1'b1;
            coins_paid <= coins_paid + 8'd1;
            state      <= CHANGE;
          end else if (tmr == TMAX) begin
            // Hopper jammed or empty: abandon the rest of this payout.
            fault     <= 1'b1;
            remaining <= '0;
            state     <= IDLE;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: cycle-indexed stimulus with hand-computed
// expected cycles/counts. Cycle 0 is the cycle a request is presented.
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out = 1'b0;
  logic [1:0] change = 2'd0;
  logic       drop = 1'b0;
  logic       coin_sense = 1'b0;
  logic       motor, eject, busy, fault, ovf;
  logic [7:0] coins_paid;
`ifdef VEND_STOCK_EN
  logic       sold_out;
`endif

  int errors = 0;
  int checks = 0;

  int cyc, motor_hi, ej_cnt, first_motor, last_motor, first_ej, last_ej;
  int drop_dly  = 0;   // drop this many cycles after last motor cycle; 0 = never
  int coin_dly  = 2;   // coin_sense this many cycles after each eject
  int coin_left = -1;  // coins the hopper will confirm; -1 = unlimited

  // Free-running clock.
  always #5 clk = ~clk;

`ifdef VEND_STOCK_EN
  vend_dispenser #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(255), .STOCK_INIT(1)) dut (
`else
  vend_dispenser #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(255)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .out        (out),
    .change     (change),
    .motor      (motor),
    .drop       (drop),
    .eject      (eject),
    .coin_sense (coin_sense),
    .busy       (busy),
    .fault      (fault),
    .ovf        (ovf),
    .coins_paid (coins_paid)
`ifdef VEND_STOCK_EN
    ,
    .sold_out   (sold_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; motor_hi = 0; ej_cnt = 0;
    first_motor = -1; last_motor = -1; first_ej = -1; last_ej = -1;
  endtask

  // Advance one cycle, record outputs, and play the sensor model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (motor) begin
      motor_hi++;
      if (first_motor < 0) first_motor = cyc;
      last_motor = cyc;
    end
    if (eject) begin
      ej_cnt++;
      if (first_ej < 0) first_ej = cyc;
      last_ej = cyc;
    end
    drop = (drop_dly > 0) && (last_motor >= 0) && !motor && (cyc == last_motor + drop_dly);
    coin_sense = (coin_left != 0) && (last_ej >= 0) && (cyc == last_ej + coin_dly);
    if (coin_sense && coin_left > 0) coin_left--;
  endtask

  task automatic req(input logic v, input logic [1:0] c);
    out = v; change = c;
    clr();
    tick();
    out = 1'b0; change = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_cyc);
    while (busy && cyc < 2000) tick();
    check({tag, "_idle_tmo"}, busy, 0);
    check({tag, "_idle_cyc"}, cyc, exp_cyc);
  endtask

  // Hard stop in case the stimulus itself wedges.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    clr();
    tick(); tick();
    rst = 1'b0;
    check("rst_motor", motor, 0);
    check("rst_eject", eject, 0);
    check("rst_fault", fault, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_coins", coins_paid, 0);

    // Spurious sensors while idle are ignored.
    drop = 1'b1; coin_sense = 1'b1;
    tick();
    check("spur_coins", coins_paid, 0);
    check("spur_busy", busy, 0);

    // Vend with two coins of change.
    drop_dly = 3; coin_dly = 2; coin_left = -1;
    req(1'b1, 2'd2);
    check("t1_motor_c1", motor, 0);
    check("t1_busy_c1", busy, 1);
    tick();
    check("t1_motor_c2", motor, 1);
    wait_idle("t1", 22);
    check("t1_motor_len", motor_hi, 8);
    check("t1_first_motor", first_motor, 2);
    check("t1_ej_cnt", ej_cnt, 2);
    check("t1_first_ej", first_ej, 14);
    check("t1_last_ej", last_ej, 18);
    check("t1_coins", coins_paid, 2);
    check("t1_fault", fault, 0);

    // Drop never arrives: timeout after 255 WAIT_DROP cycles, coin still paid.
    drop_dly = 0;
    req(1'b1, 2'd1);
    while (cyc < 264) tick();
    check("t2_fault_before", fault, 0);
    tick();
    check("t2_fault_at", fault, 1);
    wait_idle("t2", 270);
    check("t2_first_ej", first_ej, 266);
    check("t2_ej_cnt", ej_cnt, 1);
    check("t2_coins", coins_paid, 3);

    // Reset in the middle of MOTOR with another request still queued.
    drop_dly = 3;
    req(1'b1, 2'd2);
    tick(); tick();
    change = 2'd1;
    tick();
    change = 2'd0;
    tick();
    check("t5_motor_pre", motor, 1);
    do_reset();
    check("t5_motor", motor, 0);
    check("t5_busy", busy, 0);
    check("t5_coins", coins_paid, 0);
    check("t5_fault", fault, 0);
    repeat (10) tick();
    check("t5_motor_len", motor_hi, 4);
    check("t5_no_eject", ej_cnt, 0);

    // Coin timeout: only the first of three coins is sensed.
    drop_dly = 0; coin_dly = 2; coin_left = 1;
    req(1'b0, 2'd3);
    wait_idle("t3", 263);
    check("t3_first_ej", first_ej, 3);
    check("t3_ej_cnt", ej_cnt, 2);
    check("t3_coins", coins_paid, 1);
    check("t3_fault", fault, 1);

    // Minimum eject spacing with immediate sensing.
    coin_dly = 1; coin_left = -1;
    req(1'b0, 2'd3);
    wait_idle("t6", 12);
    check("t6_first_ej", first_ej, 3);
    check("t6_last_ej", last_ej, 9);
    check("t6_ej_cnt", ej_cnt, 3);
    check("t6_coins", coins_paid, 4);

    // Overflow: five change-only pushes behind a vend; the fifth is lost.
    do_reset();
    drop_dly = 3; coin_dly = 1; coin_left = -1;
    req(1'b1, 2'd0);
    repeat (5) begin
      change = 2'd1;
      if (cyc == 5) check("t4_ovf_before", ovf, 0);
      tick();
    end
    change = 2'd0;
    check("t4_ovf_set", ovf, 1);
    wait_idle("t4", 34);
    check("t4_ej_cnt", ej_cnt, 4);
    check("t4_coins", coins_paid, 4);
    check("t4_fault", fault, 0);

    // Push and pop in the same cycle while full: nothing lost.
    do_reset();
    req(1'b1, 2'd0);
    tick();
    repeat (4) begin
      change = 2'd1;
      tick();
    end
    change = 2'd0;
    while (cyc < 14) tick();
    change = 2'd1;
    tick();
    change = 2'd0;
    wait_idle("t4b", 39);
    check("t4b_ovf", ovf, 0);
    check("t4b_ej_cnt", ej_cnt, 5);
    check("t4b_coins", coins_paid, 5);

`ifdef VEND_STOCK_EN
    // Stock exhaustion with a single unit in stock.
    do_reset();
    check("t7_sold_rst", sold_out, 0);
    drop_dly = 3;
    req(1'b1, 2'd0);
    wait_idle("t7a", 14);
    check("t7_motor_len", motor_hi, 8);
    check("t7_sold_out", sold_out, 1);
    req(1'b1, 2'd0);
    wait_idle("t7b", 3);
    check("t7_no_motor", motor_hi, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
# vend_dispenser

Dispense-side actuator controller that sits downstream of the coin-accepting vending FSM. It consumes that FSM's per-cycle vend strobe (`out`) and 2-bit change code (`change`) and buffers each request. Requests are executed one at a time: the product motor is pulsed and the drop sensor is awaited, then the coin hopper ejects the owed change coin by coin, with sense handshakes and timeouts.

## Interface
- `MOTOR_CYCLES`, 8: cycles `motor` stays high per vend (≥1).
- `TIMEOUT_CYCLES`, 255: maximum wait cycles for `drop` or `coin_sense` (≥1, ≤255).
- `STOCK_INIT`, 15: initial product count; used only with `VEND_STOCK_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `out`  in  1  vend request strobe from the vending FSM.
- `change`  in  2  coins owed (0–3) from the vending FSM.
- `motor`  out  1  product motor drive.
- `drop`  in  1  product-drop sensor, active high.
- `eject`  out  1  hopper eject pulse, one cycle per coin.
- `coin_sense`  in  1  hopper coin-passed sensor, active high.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `fault`  out  1  sticky; set on any timeout.
- `ovf`  out  1  sticky; set when a request is lost to a full FIFO.
- `coins_paid`  out  8  running count of sensed coins; wraps 255→0.
- `sold_out`  out  1  present only with `VEND_STOCK_EN`.

## Operation
- **Request capture:** a request is pushed when `out==1` or `change!=0`. Each entry is {vend, change}. The FIFO is 4 entries deep.
- **FIFO full:** a push into a full FIFO discards the request and sets `ovf`. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- **FSM states:** IDLE, MOTOR, WAIT_DROP, CHANGE, EJECT, WAIT_COIN.
- **IDLE:** if the FIFO is non-empty, pop the entry and load `remaining` with its change value.
  - If vend=1, go to MOTOR.
  - Otherwise, go to CHANGE.
- **MOTOR:** `motor=1` for exactly `MOTOR_CYCLES` cycles, then go to WAIT_DROP. `drop` is ignored in this state.
- **WAIT_DROP:** on `drop=1`, go to CHANGE. After `TIMEOUT_CYCLES` cycles without `drop`, set `fault` and go to CHANGE, so change is still paid.
- **CHANGE:** if `remaining==0`, go to IDLE; otherwise go to EJECT.
- **EJECT:** `eject=1` for one cycle, then go to WAIT_COIN.
- **WAIT_COIN:** on `coin_sense=1`, decrement `remaining`, increment `coins_paid`, and go to CHANGE. On timeout, set `fault`, clear `remaining`, and go to IDLE; the remaining coins are abandoned.
- **Spurious sensor inputs:** `drop` and `coin_sense` outside their wait states are ignored.
- **Timeout counter:** 8 bits, cleared on entry to each wait state.
- **Reset values:** `motor`, `eject`, `fault`, `ovf` and `busy` are 0; `coins_paid` is 0; the FIFO is empty; the state is IDLE.
- **Reset mid-operation:** reset wins over every other event and aborts any motor or eject activity in the same cycle.

## Timing
- **Capture to pop:** a request presented in cycle N is written at the edge ending cycle N. IDLE pops it in cycle N+1.
- **Motor start:** `motor` rises in cycle N+2 and holds for `MOTOR_CYCLES` cycles.
- **Change-only start:** for a change-only request, `eject` rises in cycle N+3 (IDLE→CHANGE→EJECT).
- **Eject spacing:** the minimum spacing between `eject` pulses is 3 cycles (EJECT, WAIT_COIN with immediate sense, CHANGE).
- **Registered outputs:** all outputs are registered Moore outputs.
- **Sensor sampling:** `drop` and `coin_sense` are sampled synchronously with no internal synchroniser; the upstream logic provides it.
- **Timeout instant:** the timeout is taken in the cycle in which the counter equals `TIMEOUT_CYCLES-1` with the sensor still low. A sensor arriving in that same cycle counts as success.

## Configuration
- **`VEND_STOCK_EN` defined:**
  - An 8-bit stock counter resets to `STOCK_INIT` and decrements on each successful `drop` in WAIT_DROP.
  - `sold_out` is 1 while the counter is 0.
  - A vend entry popped while sold out skips MOTOR and WAIT_DROP and goes directly to CHANGE.
  - Reset restores `STOCK_INIT`.
- **`VEND_STOCK_EN` undefined:** no stock counter, no `sold_out` port, and every vend entry pulses the motor.

## Structure
- **Package `vend_pkg`:**
  - state enum `disp_state_t`
  - `CHANGE_W=2`
  - `FIFO_DEPTH=4`
  - entry struct `vend_req_t` {vend, change}
- **Sub-module `vend_req_fifo`:** synchronous 4-entry FIFO with push, pop, full, empty and an overflow strobe. The top level holds the FSM, timeout, remaining, `coins_paid` and stock logic.

## Test plan
- **Vend with change:** `out=1`, `change=2` in a single cycle; assert `drop` 3 cycles after MOTOR ends, and `coin_sense` 2 cycles after each eject. Expect `motor` high for 8 cycles, then two `eject` pulses, `coins_paid=2`, `fault=0`, and `busy` low afterwards.
- **Drop timeout:** `out=1`, `change=1`, `drop` never asserted. Expect `fault=1` after 255 cycles in WAIT_DROP, then one `eject`; the coin is still paid.
- **Coin timeout:** `change=3`, with `coin_sense` only for the first coin. Expect `coins_paid=1`, `fault=1`, FSM back in IDLE, and no third `eject`.
- **Overflow:** 5 change-only requests (`change=1`) on consecutive cycles with the FSM busy. Expect `ovf=1` and exactly 4 coins paid with prompt sensing. Also check a push and a pop in the same cycle while full: no loss.
- **Reset mid-operation:** `rst` asserted in the middle of MOTOR. Next cycle: `motor=0`, FIFO empty, `coins_paid=0`, `fault=0`, `busy=0`.
- **Stock exhaustion (`VEND_STOCK_EN`, `STOCK_INIT=1`):** two vends with `change=0`. The first pulses the motor and drops; `sold_out=1` thereafter. The second produces no `motor` pulse.
